// File: rtl/ifm_wgt_feeder.sv
// Streams IFM pixels (with zero padding) and weights from two 1-cycle-latency SRAMs into the PE array.
// Optional protocol checker enabled by defining FEEDER_CHK_EN; otherwise feed_err is tied to 0.
module ifm_wgt_feeder #(
    parameter int IFM_SIZE    = 9,
    parameter int PAD         = 2,
    parameter int KERNEL_SIZE = 4,
    parameter int CI          = 3,
    parameter int CO          = 4,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 16
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              start_conv,
    input  logic              end_conv,
    input  logic              set_ifm,
    input  logic              ifm_read,
    input  logic              wgt_read,
    output logic [ADDR_W-1:0] ifm_mem_addr,
    output logic              ifm_mem_rd,
    input  logic [DATA_W-1:0] ifm_mem_rdata,
    output logic [ADDR_W-1:0] wgt_mem_addr,
    output logic              wgt_mem_rd,
    input  logic [DATA_W-1:0] wgt_mem_rdata,
    output logic [DATA_W-1:0] ifm_pix,
    output logic              ifm_valid,
    output logic [DATA_W-1:0] wgt_out,
    output logic              wgt_valid,
    output logic              busy,
    output logic              feed_err
);

    localparam int NPIX = (IFM_SIZE - 2 * PAD) * (IFM_SIZE - 2 * PAD);
    localparam int NIFM = CI * NPIX;
    localparam int NWGT = KERNEL_SIZE * KERNEL_SIZE * CI * CO;
    localparam logic [ADDR_W-1:0] IFM_LAST = ADDR_W'(NIFM - 1);
    localparam logic [ADDR_W-1:0] WGT_LAST = ADDR_W'(NWGT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   ifm_addr_reg;
    logic [ADDR_W-1:0]   ifm_addr_next;
    logic [ADDR_W-1:0]   wgt_addr_reg;
    logic [ADDR_W-1:0]   wgt_addr_next;
    logic                ifm_valid_reg;
    logic                ifm_rd_d_reg;
    logic                wgt_valid_reg;
    logic [DATA_W-1:0]   wgt_hold_reg;
    logic                run;

    assign run        = (state_reg == S_RUN);
    assign ifm_mem_rd = run & set_ifm & ifm_read;
    assign wgt_mem_rd = run & wgt_read;

    assign ifm_mem_addr = ifm_addr_reg;
    assign wgt_mem_addr = wgt_addr_reg;

    // Counters only advance in RUN; outside RUN they are forced to 0, which clears
    // them on DRAIN->IDLE and guarantees a zero start for the next pass.
    always_comb begin
        ifm_addr_next = '0;
        wgt_addr_next = '0;
        if (run) begin
            ifm_addr_next = ifm_addr_reg;
            wgt_addr_next = wgt_addr_reg;
            if (ifm_mem_rd) begin
                ifm_addr_next = (ifm_addr_reg == IFM_LAST) ? '0 : ifm_addr_reg + ADDR_W'(1);
            end
            if (wgt_mem_rd) begin
                wgt_addr_next = (wgt_addr_reg == WGT_LAST) ? '0 : wgt_addr_reg + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            ifm_addr_reg  <= '0;
            wgt_addr_reg  <= '0;
            ifm_valid_reg <= 1'b0;
            ifm_rd_d_reg  <= 1'b0;
            wgt_valid_reg <= 1'b0;
            wgt_hold_reg  <= '0;
        end else begin
            case (state_reg)
                S_IDLE:  if (start_conv) state_reg <= S_RUN;
                S_RUN:   if (end_conv) state_reg <= S_DRAIN;
                S_DRAIN: state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
            ifm_addr_reg  <= ifm_addr_next;
            wgt_addr_reg  <= wgt_addr_next;
            ifm_valid_reg <= run & set_ifm;
            ifm_rd_d_reg  <= ifm_mem_rd;
            wgt_valid_reg <= wgt_mem_rd;
            if (wgt_valid_reg) begin
                wgt_hold_reg <= wgt_mem_rdata;
            end
        end
    end

    // SRAM data returns one cycle after the strobe, so the output mux uses the delayed strobe.
    assign ifm_valid = ifm_valid_reg;
    assign ifm_pix   = ifm_rd_d_reg ? ifm_mem_rdata : '0;
    assign wgt_valid = wgt_valid_reg;
    assign wgt_out   = wgt_valid_reg ? wgt_mem_rdata : wgt_hold_reg;
    assign busy      = (state_reg != S_IDLE);

`ifdef FEEDER_CHK_EN
    logic feed_err_reg;
    logic err_set;

    // The end-of-pass check uses the post-read counter values, so ending on the
    // final read of a complete stream (both counters wrapping to 0) is legal.
    assign err_set = (run & ifm_read & ~set_ifm)
                   | ((state_reg == S_IDLE) & (set_ifm | ifm_read | wgt_read))
                   | (run & end_conv & ((ifm_addr_next != '0) | (wgt_addr_next != '0)));

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            feed_err_reg <= 1'b0;
        end else if (err_set) begin
            feed_err_reg <= 1'b1;
        end
    end

    assign feed_err = feed_err_reg;
`else
    assign feed_err = 1'b0;
`endif

endmodule

// File: tb/tb_ifm_wgt_feeder.sv
// Scoreboard bench for ifm_wgt_feeder: randomized/raster stimulus, queue-based expected data, negedge monitor.
module tb_ifm_wgt_feeder;

    localparam int NIFM = 75;
    localparam int NWGT = 192;
`ifdef FEEDER_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk1 = 1'b0;
    logic        rst  = 1'b1;
    logic        start_conv = 1'b0, end_conv = 1'b0, set_ifm = 1'b0, ifm_read = 1'b0, wgt_read = 1'b0;
    logic [15:0] ifm_mem_addr, wgt_mem_addr;
    logic        ifm_mem_rd, wgt_mem_rd;
    logic [7:0]  ifm_mem_rdata = 8'h00, wgt_mem_rdata = 8'h00;
    logic [7:0]  ifm_pix, wgt_out;
    logic        ifm_valid, wgt_valid, busy, feed_err;

    always #5 clk1 = ~clk1;

    ifm_wgt_feeder dut (
        .clk1(clk1), .rst(rst), .start_conv(start_conv), .end_conv(end_conv),
        .set_ifm(set_ifm), .ifm_read(ifm_read), .wgt_read(wgt_read),
        .ifm_mem_addr(ifm_mem_addr), .ifm_mem_rd(ifm_mem_rd), .ifm_mem_rdata(ifm_mem_rdata),
        .wgt_mem_addr(wgt_mem_addr), .wgt_mem_rd(wgt_mem_rd), .wgt_mem_rdata(wgt_mem_rdata),
        .ifm_pix(ifm_pix), .ifm_valid(ifm_valid), .wgt_out(wgt_out), .wgt_valid(wgt_valid),
        .busy(busy), .feed_err(feed_err)
    );

    // SRAM models: 1-cycle read latency, garbage on the bus when not read
    logic [7:0] ifm_sram [0:NIFM-1];
    logic [7:0] wgt_sram [0:NWGT-1];
    always @(posedge clk1) begin
        ifm_mem_rdata <= ifm_mem_rd ? ifm_sram[ifm_mem_addr] : 8'($urandom);
        wgt_mem_rdata <= wgt_mem_rd ? wgt_sram[wgt_mem_addr] : 8'($urandom);
    end

    int tests = 0;
    int fails = 0;
    int obs_ifm_rd = 0;
    int obs_ifm_valid = 0;
    bit mon_en = 1'b0;

    // reference model state
    logic [7:0] pix_q[$];
    logic [7:0] wgt_q[$];
    int  m_phase = 0;           // 0 idle, 1 run, 2 drain
    int  m_ifm = 0, m_wgt = 0;
    bit  err_sticky = 1'b0;
    bit  exp_busy = 1'b0, exp_ifm_rd = 1'b0, exp_wgt_rd = 1'b0, exp_err = 1'b0;
    int  exp_ifm_addr = 0, exp_wgt_addr = 0;
    logic [7:0] last_wgt = 8'h00;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus; model predicts this cycle's strobes and queues the data outputs.
    task automatic cycle(input bit sc, input bit ec, input bit si, input bit ir, input bit wr);
        bit err_set;
        int nxt;
        @(posedge clk1); #1;
        start_conv = sc; end_conv = ec; set_ifm = si; ifm_read = ir; wgt_read = wr;
        exp_busy = (m_phase != 0);
        exp_ifm_rd = 1'b0; exp_wgt_rd = 1'b0;
        exp_ifm_addr = m_ifm; exp_wgt_addr = m_wgt;
        exp_err = err_sticky;
        err_set = 1'b0;
        nxt = m_phase;
        case (m_phase)
            0: begin
                err_set = si | ir | wr;
                if (sc) nxt = 1;
            end
            1: begin
                if (si) pix_q.push_back(ir ? ifm_sram[m_ifm] : 8'h00);
                if (si && ir) begin
                    exp_ifm_rd = 1'b1;
                    m_ifm = (m_ifm + 1) % NIFM;
                end
                if (ir && !si) err_set = 1'b1;
                if (wr) begin
                    exp_wgt_rd = 1'b1;
                    wgt_q.push_back(wgt_sram[m_wgt]);
                    m_wgt = (m_wgt + 1) % NWGT;
                end
                if (ec) begin
                    if (m_ifm != 0 || m_wgt != 0) err_set = 1'b1;
                    nxt = 2;
                end
            end
            default: begin
                m_ifm = 0; m_wgt = 0; nxt = 0;
            end
        endcase
        err_sticky = err_sticky | (CHK_EN & err_set);
        m_phase = nxt;
    endtask

    task automatic rnd_run;
        bit si;
        si = ($urandom % 4) != 0;
        cycle(($urandom % 16) == 0, 1'b0, si, 1'($urandom), 1'($urandom));
    endtask

    always @(negedge clk1) begin
        logic [7:0] e;
        if (mon_en) begin
            chk("busy", busy, exp_busy);
            chk("ifm_mem_rd", ifm_mem_rd, exp_ifm_rd);
            chk("ifm_mem_addr", ifm_mem_addr, exp_ifm_addr);
            chk("wgt_mem_rd", wgt_mem_rd, exp_wgt_rd);
            chk("wgt_mem_addr", wgt_mem_addr, exp_wgt_addr);
            chk("feed_err", feed_err, exp_err);
            if (ifm_mem_rd) obs_ifm_rd++;
            if (ifm_valid) begin
                obs_ifm_valid++;
                if (pix_q.size() == 0) chk("ifm_valid_unexpected", 1, 0);
                else begin
                    e = pix_q.pop_front();
                    chk("ifm_pix", ifm_pix, e);
                end
            end else begin
                chk("ifm_pix_when_invalid", ifm_pix, 0);
            end
            if (wgt_valid) begin
                if (wgt_q.size() == 0) chk("wgt_valid_unexpected", 1, 0);
                else begin
                    e = wgt_q.pop_front();
                    chk("wgt_out", wgt_out, e);
                    last_wgt = e;
                end
            end else begin
                chk("wgt_out_hold", wgt_out, last_wgt);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_ifm_pix"}, ifm_pix, 0);
        chk({tag, "_ifm_valid"}, ifm_valid, 0);
        chk({tag, "_wgt_out"}, wgt_out, 0);
        chk({tag, "_wgt_valid"}, wgt_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_feed_err"}, feed_err, 0);
        chk({tag, "_ifm_mem_rd"}, ifm_mem_rd, 0);
        chk({tag, "_wgt_mem_rd"}, wgt_mem_rd, 0);
        chk({tag, "_ifm_mem_addr"}, ifm_mem_addr, 0);
        chk({tag, "_wgt_mem_addr"}, wgt_mem_addr, 0);
    endtask

    initial begin
        int k;
        bit interior;
        for (int i = 0; i < NIFM; i++) ifm_sram[i] = 8'($urandom_range(1, 255));
        for (int i = 0; i < NWGT; i++) wgt_sram[i] = 8'($urandom_range(1, 255));

        // reset state
        repeat (2) @(posedge clk1);
        @(negedge clk1);
        check_all_zero("reset");
        @(posedge clk1); #1;
        rst = 1'b0;
        mon_en = 1'b1;
        $display("[TB] reset released");

        // strobes in IDLE must not read
        repeat (5) cycle(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
        $display("[TB] idle strobes done");

        // full padded raster: 4 filters x 3 channels x 9x9 slots, 200 weight reads
        obs_ifm_rd = 0; obs_ifm_valid = 0;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        k = 0;
        for (int f = 0; f < 4; f++)
            for (int ch = 0; ch < 3; ch++)
                for (int r = 0; r < 9; r++)
                    for (int c = 0; c < 9; c++) begin
                        interior = (r >= 2 && r < 7 && c >= 2 && c < 7);
                        k++;
                        cycle(($urandom % 16) == 0, 1'b0, 1'b1, interior, k <= 200);
                    end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk1);
        chk("raster_ifm_rd_total", obs_ifm_rd, 300);
        chk("raster_ifm_valid_total", obs_ifm_valid, 972);
        $display("[TB] raster pass: %0d reads, %0d valid pixels", obs_ifm_rd, obs_ifm_valid);

        // end_conv coincident with the final IFM read of a channel stream
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 3000 && m_ifm != NIFM - 1; n++) rnd_run();
        chk("reach_addr_74", m_ifm, NIFM - 1);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'($urandom));
        cycle(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("[TB] end-on-last-read pass done");

        // reset in the middle of a pass at IFM address 37
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 3000 && m_ifm != 37; n++) rnd_run();
        chk("reach_addr_37", m_ifm, 37);
        @(posedge clk1); #1;
        chk("addr_before_rst", ifm_mem_addr, 37);
        #1;
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        check_all_zero("midrun_rst");
        start_conv = 1'b0; end_conv = 1'b0; set_ifm = 1'b0; ifm_read = 1'b0; wgt_read = 1'b0;
        pix_q.delete(); wgt_q.delete();
        m_phase = 0; m_ifm = 0; m_wgt = 0; err_sticky = 1'b0; last_wgt = 8'h00;
        exp_busy = 1'b0; exp_ifm_rd = 1'b0; exp_wgt_rd = 1'b0; exp_err = 1'b0;
        exp_ifm_addr = 0; exp_wgt_addr = 0;
        @(posedge clk1); #1;
        rst = 1'b0;
        mon_en = 1'b1;
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (30) rnd_run();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("[TB] mid-run reset and restart done");

        @(negedge clk1);
        chk("pix_queue_drained", pix_q.size(), 0);
        chk("wgt_queue_drained", wgt_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ifm_wgt_feeder.md
IFM_WGT_FEEDER -- requirements
Module: ifm_wgt_feeder

Interface
REQ-001 Parameters (name, default, meaning): IFM_SIZE 9 padded IFM side; PAD 2 padding width; KERNEL_SIZE 4 kernel side; CI 3 input channels; CO 4 output filters; DATA_W 8 pixel/weight width; ADDR_W 16 memory address width.
REQ-002 Ports (name, direction, width, meaning); clock and reset first:
- clk1 in 1: single clock; all logic on rising edge.
- rst in 1: asynchronous, active-high reset.
- start_conv in 1: convolution start pulse.
- end_conv in 1: convolution finished pulse.
- set_ifm in 1: IFM pixel slot this cycle.
- ifm_read in 1: slot is interior (memory) pixel.
- wgt_read in 1: weight slot this cycle.
- ifm_mem_addr out ADDR_W: IFM SRAM address.
- ifm_mem_rd out 1: IFM SRAM read strobe.
- ifm_mem_rdata in DATA_W: IFM SRAM data, 1-cycle latency.
- wgt_mem_addr out ADDR_W: weight SRAM address.
- wgt_mem_rd out 1: weight SRAM read strobe.
- wgt_mem_rdata in DATA_W: weight SRAM data, 1-cycle latency.
- ifm_pix out DATA_W: pixel to PE array.
- ifm_valid out 1: ifm_pix valid.
- wgt_out out DATA_W: weight to PE array.
- wgt_valid out 1: wgt_out valid.
- busy out 1: state is not IDLE.
- feed_err out 1: sticky protocol error (see REQ-019).

Function
REQ-003 States IDLE, RUN, DRAIN; IDLE->RUN on start_conv; RUN->DRAIN on end_conv; DRAIN->IDLE after exactly 1 cycle; start_conv outside IDLE ignored.
REQ-004 Interior pixel count per channel NPIX = (IFM_SIZE-2*PAD)^2; IFM wrap count NIFM = CI*NPIX; weight wrap count NWGT = KERNEL_SIZE^2*CI*CO.
REQ-005 ifm_mem_rd = ifm_read & set_ifm in RUN, combinational; 0 in IDLE/DRAIN.
REQ-006 ifm_mem_addr = IFM address counter; counter increments after each ifm_mem_rd cycle, wraps NIFM-1 -> 0 (re-read IFM for next filter).
REQ-007 wgt_mem_rd = wgt_read in RUN; wgt_mem_addr = weight counter; increments after each wgt_mem_rd cycle, wraps NWGT-1 -> 0.
REQ-008 Output latency 1 cycle: ifm_valid(t+1) = set_ifm(t) in RUN; ifm_pix(t+1) = ifm_mem_rdata if ifm_mem_rd(t), else 0 (zero padding).
REQ-009 wgt_valid(t+1) = wgt_mem_rd(t); wgt_out = wgt_mem_rdata when wgt_valid, else holds last value.
REQ-010 ifm_pix is 0 whenever ifm_valid is 0.
REQ-011 ifm_read without set_ifm: no read, no address change.
REQ-012 Simultaneous end_conv and set_ifm/wgt_read in RUN: that cycle's reads still issue; outputs appear in the DRAIN cycle.
REQ-013 DRAIN: no new reads; counters clear to 0 on entry to IDLE.
REQ-014 start_conv in IDLE clears both counters before the first RUN cycle.
REQ-015 busy = 1 in RUN and DRAIN.

Reset
REQ-016 rst asserted: state IDLE, both counters 0, ifm_pix 0, ifm_valid 0, wgt_out 0, wgt_valid 0, feed_err 0, immediately and asynchronously.
REQ-017 rst mid-RUN aborts the pass; no read strobe in the cycle after rst deasserts unless start_conv restarts.
REQ-018 All outputs are defined (0) during reset; mem strobes are 0.

Configuration
REQ-019 Macro FEEDER_CHK_EN defined: feed_err sets on ifm_read&!set_ifm in RUN, on any strobe input in IDLE, or on end_conv while either counter is non-zero; cleared only by rst.
REQ-020 FEEDER_CHK_EN undefined: no check logic; feed_err tied to 0.

Verification
REQ-021 Defaults, start_conv, 5x5 interior per channel, 3 channels, 4 filters with padded raster -> 300 ifm_mem_rd total, IFM addr sequence 0..74 repeated 4x, 81*12 ifm_valid pulses, zeros on 56 padding slots per channel.
REQ-022 Weight stream of 192 wgt_read cycles -> wgt_mem_addr 0..191, wrap to 0, wgt_out matches SRAM[addr] 1 cycle later.
REQ-023 end_conv coincident with final ifm_read -> last pixel valid in DRAIN, busy falls next cycle, counters 0.
REQ-024 rst pulse at IFM addr 37 -> all outputs 0 same cycle; restart reads from addr 0.
REQ-025 FEEDER_CHK_EN defined, ifm_read=1 with set_ifm=0 in RUN -> feed_err=1 next cycle, sticky; undefined -> feed_err stays 0.
REQ-026 start_conv while RUN -> ignored, counters continue uninterrupted.
